// File: rtl/melody_sequencer_pkg.sv
// Shared types for the melody sequencer: FSM states and note table entry layout.
package melody_sequencer_pkg;

   localparam int unsigned HALF_PERIOD_W = 16;
   localparam int unsigned DURATION_W    = 8;
   localparam int unsigned ENTRY_W       = HALF_PERIOD_W + DURATION_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP,
      ST_DONE
   } state_t;

   // Table entry: half_period in clock cycles (0 = rest), duration in ticks (0 = end marker)
   typedef struct packed {
      logic [HALF_PERIOD_W-1:0] half_period;
      logic [DURATION_W-1:0]    duration;
   } note_entry_t;

endpackage

// File: rtl/melody_sequencer_tone_core.sv
// Square-wave generator: toggles out every half_period cycles while enabled.
module tone_core
   import melody_sequencer_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     restart,
   input  logic [HALF_PERIOD_W-1:0] half_period,
   output logic                     out
);

   logic [HALF_PERIOD_W-1:0] count;

   // Phase counter and output toggle; held at zero when disabled or restarted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         out   <= 1'b0;
      end else if (!enable || restart) begin
         count <= '0;
         out   <= 1'b0;
      end else if (count == half_period - HALF_PERIOD_W'(1)) begin
         count <= '0;
         out   <= ~out;
      end else begin
         count <= count + HALF_PERIOD_W'(1);
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Note-table driven melody player: plays each entry for duration ticks, then a one-tick gap.
module melody_sequencer
   import melody_sequencer_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 12000000,
   parameter int unsigned TICK_HZ         = 100,
   parameter int unsigned SONG_LEN        = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        loop_en,
   input  logic                        wr_en,
   input  logic [$clog2(SONG_LEN)-1:0] wr_addr,
   input  logic [ENTRY_W-1:0]          wr_data,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(SONG_LEN)-1:0] note_index,
   output logic                        tone_en,
   output logic                        audio_out
);

   localparam int unsigned TICKS_PER_CYCLE = CLOCK_FREQUENCY / TICK_HZ;
   localparam int unsigned TICK_W = (TICKS_PER_CYCLE > 1) ? $clog2(TICKS_PER_CYCLE) : 1;
   localparam int unsigned IDX_W  = $clog2(SONG_LEN);

   state_t                   state;
   note_entry_t              note_table [SONG_LEN];
   logic [HALF_PERIOD_W-1:0] half_period_q;
   logic [DURATION_W-1:0]    dur_cnt;
   logic [TICK_W-1:0]        tick_cnt;

   note_entry_t entry_c;
   logic        tick_wrap_c;
   logic        last_c;
   logic        note_end_c;
   logic        tone_on_c;
   logic        restart_c;

   // Table write port, open only while idle; contents survive reset
   always_ff @(posedge clock) begin
      if (wr_en && state == ST_IDLE) begin
         note_table[wr_addr] <= note_entry_t'(wr_data);
      end
   end

   // Next-cycle tone enable so the tone core silences on the same edge tone_en drops
   always_comb begin
      entry_c     = note_table[note_index];
      tick_wrap_c = (tick_cnt == TICK_W'(TICKS_PER_CYCLE - 1));
      last_c      = (note_index == IDX_W'(SONG_LEN - 1));
      note_end_c  = (state == ST_PLAY) && tick_wrap_c && (dur_cnt == DURATION_W'(1));
      restart_c   = (state == ST_LOAD);
      tone_on_c   = !stop &&
                    (((state == ST_LOAD) && (entry_c.duration != '0) && (entry_c.half_period != '0)) ||
                     ((state == ST_PLAY) && tone_en && !note_end_c));
   end

   // Playback FSM with registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         note_index    <= '0;
         tone_en       <= 1'b0;
         half_period_q <= '0;
         dur_cnt       <= '0;
         tick_cnt      <= '0;
      end else begin
         done    <= 1'b0;
         tone_en <= tone_on_c;
         if (state != ST_IDLE && stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dur_cnt  <= '0;
            tick_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !stop) begin
                     state      <= ST_LOAD;
                     busy       <= 1'b1;
                     note_index <= '0;
                  end
               end
               ST_LOAD: begin
                  if (entry_c.duration == '0) begin
                     // An end marker at entry 0 never loops, avoiding an empty infinite song
                     if (loop_en && note_index != '0) begin
                        state      <= ST_LOAD;
                        note_index <= '0;
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     half_period_q <= entry_c.half_period;
                     dur_cnt       <= entry_c.duration;
                     tick_cnt      <= '0;
                     state         <= ST_PLAY;
                  end
               end
               ST_PLAY: begin
                  if (tick_wrap_c) begin
                     tick_cnt <= '0;
                     if (dur_cnt == DURATION_W'(1)) begin
                        state <= ST_GAP;
                     end else begin
                        dur_cnt <= dur_cnt - DURATION_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               ST_GAP: begin
                  if (tick_wrap_c) begin
                     tick_cnt <= '0;
                     if (!last_c) begin
                        state      <= ST_LOAD;
                        note_index <= note_index + IDX_W'(1);
                     end else if (loop_en) begin
                        state      <= ST_LOAD;
                        note_index <= '0;
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   tone_core u_tone_core (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (tone_on_c),
      .restart     (restart_c),
      .half_period (half_period_q),
      .out         (audio_out)
   );

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (TICKS_PER_CYCLE=10, SONG_LEN=4).
module tb_melody_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [23:0] wr_data;
   logic        busy;
   logic        done;
   logic [1:0]  note_index;
   logic        tone_en;
   logic        audio_out;

   int errors = 0;
   int checks = 0;

   melody_sequencer #(
      .CLOCK_FREQUENCY (1000),
      .TICK_HZ         (100),
      .SONG_LEN        (4)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .note_index (note_index),
      .tone_en    (tone_en),
      .audio_out  (audio_out)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_entry(input logic [1:0] a, input logic [15:0] hp, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = {hp, d};
      step();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      #2;
      checks++;
      if ({busy, done, tone_en, audio_out} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: busy,done,tone_en,audio=%b required 0000",
                  {busy, done, tone_en, audio_out});
      end
      checks++;
      if (note_index !== 2'd0) begin
         errors++;
         $display("FAIL reset_index: note_index=%0d required 0", note_index);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b required 0", busy);
      end
   endtask

   // Two-tick tone, one-tick rest, end marker; a start pulse mid-note must not disturb it
   task automatic test_basic_song();
      logic [3:0] exp_v;
      logic [1:0] exp_idx;
      logic       e_tone;
      logic       e_aud;
      int         done_seen = 0;
      write_entry(2'd0, 16'd3, 8'd2);
      write_entry(2'd1, 16'd0, 8'd1);
      write_entry(2'd2, 16'd0, 8'd0);
      write_entry(2'd3, 16'd7, 8'd1);
      loop_en = 1'b0;
      pulse_start();
      checks++;
      if ({busy, tone_en, note_index} !== 4'b1000) begin
         errors++;
         $display("FAIL basic_load: busy,tone_en,idx=%b required 1000", {busy, tone_en, note_index});
      end
      step();
      for (int k = 0; k < 56; k++) begin
         e_tone  = (k < 20);
         e_aud   = e_tone && (((k / 3) % 2) == 1);
         exp_v   = {(k < 53), e_tone, e_aud, (k == 52)};
         exp_idx = (k < 30) ? 2'd0 : ((k < 51) ? 2'd1 : 2'd2);
         if (done) done_seen++;
         checks++;
         if ({busy, tone_en, audio_out, done} !== exp_v) begin
            errors++;
            $display("FAIL basic_outputs k=%0d: busy,tone_en,audio,done=%b required %b",
                     k, {busy, tone_en, audio_out, done}, exp_v);
         end
         if (k <= 52) begin
            checks++;
            if (note_index !== exp_idx) begin
               errors++;
               $display("FAIL basic_index k=%0d: note_index=%0d required %0d", k, note_index, exp_idx);
            end
         end
         if (k == 5) start = 1'b1;
         if (k == 6) start = 1'b0;
         step();
      end
      checks++;
      if (done_seen != 1) begin
         errors++;
         $display("FAIL basic_done_count: pulses=%0d required 1", done_seen);
      end
   endtask

   // Looping over all four entries, then dropping loop_en finishes after entry 3
   task automatic test_loop();
      logic [3:0] exp_v;
      logic [1:0] exp_idx;
      logic       e_tone;
      int         p;
      for (int i = 0; i < 4; i++) write_entry(2'(i), 16'd2, 8'd1);
      loop_en = 1'b1;
      pulse_start();
      for (int s = 0; s < 171; s++) begin
         p = s % 21;
         if (s < 168) begin
            e_tone = (p >= 1) && (p <= 10);
            exp_v  = {1'b1, e_tone, e_tone && ((((p - 1) / 2) % 2) == 1), 1'b0};
         end else begin
            exp_v  = {(s == 168), 1'b0, 1'b0, (s == 168)};
         end
         exp_idx = (s < 168) ? 2'((s / 21) % 4) : 2'd3;
         checks++;
         if ({busy, tone_en, audio_out, done} !== exp_v) begin
            errors++;
            $display("FAIL loop_outputs s=%0d: busy,tone_en,audio,done=%b required %b",
                     s, {busy, tone_en, audio_out, done}, exp_v);
         end
         if (s <= 168) begin
            checks++;
            if (note_index !== exp_idx) begin
               errors++;
               $display("FAIL loop_index s=%0d: note_index=%0d required %0d", s, note_index, exp_idx);
            end
         end
         if (s == 125) loop_en = 1'b0;
         step();
      end
   endtask

   // Stop mid-note aborts silently; start with stop in idle does nothing
   task automatic test_stop();
      write_entry(2'd0, 16'd4, 8'd5);
      loop_en = 1'b0;
      pulse_start();
      for (int i = 0; i < 8; i++) step();
      checks++;
      if ({tone_en, audio_out} !== 2'b11) begin
         errors++;
         $display("FAIL stop_pre: tone_en,audio=%b required 11", {tone_en, audio_out});
      end
      stop = 1'b1;
      step();
      checks++;
      if ({busy, tone_en, audio_out, done} !== 4'b0000) begin
         errors++;
         $display("FAIL stop_abort: busy,tone_en,audio,done=%b required 0000",
                  {busy, tone_en, audio_out, done});
      end
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL stop_start_idle %0d: busy,done=%b required 00", i, {busy, done});
         end
      end
      start = 1'b0;
      stop  = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_release: busy=%b required 0", busy);
      end
   endtask

   // A write during playback is dropped; the same write while idle lands
   task automatic test_write_gating();
      logic e_aud;
      write_entry(2'd0, 16'd3, 8'd1);
      write_entry(2'd1, 16'd2, 8'd1);
      write_entry(2'd2, 16'd0, 8'd0);
      pulse_start();
      for (int s = 0; s < 45; s++) begin
         if (s >= 22 && s <= 31) begin
            e_aud = (((s - 22) / 2) % 2) == 1;
            checks++;
            if (audio_out !== e_aud) begin
               errors++;
               $display("FAIL write_busy_old s=%0d: audio=%b required %b", s, audio_out, e_aud);
            end
         end
         if (s == 43 || s == 44) begin
            checks++;
            if ({busy, done} !== ((s == 43) ? 2'b11 : 2'b00)) begin
               errors++;
               $display("FAIL write_busy_end s=%0d: busy,done=%b", s, {busy, done});
            end
         end
         if (s == 3) begin
            wr_en = 1'b1; wr_addr = 2'd1; wr_data = {16'd5, 8'd1};
         end
         if (s == 4) wr_en = 1'b0;
         step();
      end
      write_entry(2'd1, 16'd5, 8'd1);
      pulse_start();
      for (int s = 0; s < 32; s++) begin
         if (s >= 22) begin
            e_aud = (((s - 22) / 5) % 2) == 1;
            checks++;
            if ({tone_en, audio_out} !== {1'b1, e_aud}) begin
               errors++;
               $display("FAIL write_idle_new s=%0d: tone_en,audio=%b required %b",
                        s, {tone_en, audio_out}, {1'b1, e_aud});
            end
         end
         step();
      end
      wait_idle(40);
   endtask

   // End marker at entry 0 finishes even with loop_en; held start is ignored while busy
   task automatic test_marker_entry0();
      write_entry(2'd0, 16'd0, 8'd0);
      loop_en = 1'b1;
      start   = 1'b1;
      step();
      checks++;
      if ({busy, done, note_index} !== 4'b1000) begin
         errors++;
         $display("FAIL marker_load: busy,done,idx=%b required 1000", {busy, done, note_index});
      end
      step();
      checks++;
      if ({busy, done} !== 2'b11) begin
         errors++;
         $display("FAIL marker_done: busy,done=%b required 11", {busy, done});
      end
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL marker_idle %0d: busy,done=%b required 00", i, {busy, done});
         end
      end
      loop_en = 1'b0;
   endtask

   // Asynchronous reset mid-note clears outputs; table is preserved
   task automatic test_reset_mid();
      write_entry(2'd0, 16'd3, 8'd1);
      write_entry(2'd1, 16'd0, 8'd0);
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({tone_en, audio_out} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid_pre: tone_en,audio=%b required 11", {tone_en, audio_out});
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, tone_en, audio_out, note_index} !== 6'b000000) begin
         errors++;
         $display("FAIL rstmid_async: busy,done,tone_en,audio,idx=%b required 000000",
                  {busy, done, tone_en, audio_out, note_index});
      end
      step();
      reset_n = 1'b1;
      step();
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({tone_en, audio_out} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid_table_k3: tone_en,audio=%b required 11", {tone_en, audio_out});
      end
      for (int i = 0; i < 3; i++) step();
      checks++;
      if ({tone_en, audio_out} !== 2'b10) begin
         errors++;
         $display("FAIL rstmid_table_k6: tone_en,audio=%b required 10", {tone_en, audio_out});
      end
      wait_idle(40);
   endtask

   initial begin
      test_reset();
      test_basic_song();
      test_loop();
      test_stop();
      test_write_gating();
      test_marker_entry0();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
